// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction timer: counts while start is high, expires after TIMEOUT counted cycles.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);
  logic [9:0] cnt;

  assign expire = start && (cnt == 10'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (clear)           cnt <= '0;
    else if (start && !expire) cnt <= cnt + 10'd1;
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory, one transaction in flight.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_rvalid,
  output logic        if_stall,
  output logic        dm_stall,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);
  arb_state_e  state, state_nxt;
  arb_owner_e  owner, owner_nxt;
  logic [2:0]  streak;
  logic [31:0] if_rdata_q, dm_rdata_q;
  logic        grant_if, grant_dm, done, abort, fin, expire;
  logic        tmr_run, tmr_clear;

  assign tmr_run   = (state != ST_IDLE);
  assign tmr_clear = (state == ST_IDLE) || (state == ST_REQ && mem_gnt);

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk), .rst(rst), .start(tmr_run), .clear(tmr_clear), .expire(expire)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant_if  = (state == ST_IDLE) && if_req && (!dm_req || streak == 3'(STREAK_MAX));
    grant_dm  = (state == ST_IDLE) && dm_req && !grant_if;
    // A real response, or a grant in REQ, beats a simultaneous timeout.
    done      = (state == ST_WAIT) && mem_rvalid;
    abort     = expire && !done && !(state == ST_REQ && mem_gnt);
    fin       = done || abort;
    case (state)
      ST_IDLE: begin
        if (grant_if)      begin state_nxt = ST_REQ; owner_nxt = OWN_IF; end
        else if (grant_dm) begin state_nxt = ST_REQ; owner_nxt = OWN_DM; end
      end
      ST_REQ: begin
        if (mem_gnt)    state_nxt = ST_WAIT;
        else if (abort) begin state_nxt = ST_IDLE; owner_nxt = OWN_NONE; end
      end
      ST_WAIT: begin
        if (fin) begin state_nxt = ST_IDLE; owner_nxt = OWN_NONE; end
      end
      default: begin state_nxt = ST_IDLE; owner_nxt = OWN_NONE; end
    endcase
    // A requester that dropped its req no longer gets a completion pulse.
    if_rvalid = fin && (owner == OWN_IF) && if_req;
    dm_rvalid = fin && (owner == OWN_DM) && dm_req;
    if_rdata  = if_rvalid ? (done ? mem_rdata : NOP_INSTR) : if_rdata_q;
    dm_rdata  = dm_rvalid ? (done ? mem_rdata : 32'h0)     : dm_rdata_q;
  end

  assign mem_req  = (state == ST_REQ);
  assign if_stall = if_req && !if_rvalid;
  assign dm_stall = dm_req && !dm_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      streak     <= '0;
      bus_err    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (abort)     bus_err    <= 1'b1;
      if (if_rvalid) if_rdata_q <= if_rdata;
      if (dm_rvalid) dm_rdata_q <= dm_rdata;
      if (grant_if) begin
        streak    <= '0;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_be    <= '0;
        mem_wdata <= '0;
      end else if (grant_dm) begin
        streak    <= if_req ? ((streak == 3'd7) ? streak : streak + 3'd1) : 3'd0;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_be    <= dm_be;
        mem_wdata <= dm_wdata;
      end
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (STREAK_MAX=4, TIMEOUT=8).
module tb_unified_mem_arbiter;
  logic        clk, rst;
  logic        if_req, if_rvalid, dm_req, dm_we, dm_rvalid, if_stall, dm_stall;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be, mem_be;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          checks = 0, errors = 0;

  unified_mem_arbiter #(.STREAK_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .if_stall(if_stall), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  // Waits for mem_req, grants it, answers one cycle later with rd.
  task automatic txn(input logic [31:0] rd, output logic got_if, output logic got_dm,
                     output logic [31:0] addr);
    int n = 0;
    #1;
    while (!mem_req && n < 20) begin step(); #1; n++; end
    chk("txn_req_seen", 32'(n < 20), 32'd1);
    addr = mem_addr;
    step();
    mem_rvalid = 1'b1; mem_rdata = rd;
    #1;
    got_if = if_rvalid; got_dm = dm_rvalid;
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    logic gi, gd;
    logic [31:0] a;
    int n;
    rst = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_be = 0; dm_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #1;
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_if_rdata",  if_rdata,       32'd0);
    chk("rst_dm_rdata",  dm_rdata,       32'd0);
    chk("rst_bus_err",   32'(bus_err),   32'd0);
    @(negedge clk); rst = 1'b1; step();

    // Fetch alone, minimum latency
    if_req = 1; if_addr = 32'h10; mem_gnt = 1;
    #1; chk("lat_c0_stall", 32'(if_stall), 32'd1); chk("lat_c0_mreq", 32'(mem_req), 32'd0);
    step(); #1;
    chk("lat_c1_mreq", 32'(mem_req), 32'd1);
    chk("lat_c1_addr", mem_addr, 32'h10);
    chk("lat_c1_we",   32'(mem_we), 32'd0);
    chk("lat_c1_stall", 32'(if_stall), 32'd1);
    step();
    mem_rvalid = 1; mem_rdata = 32'h0050_0093; #1;
    chk("lat_c2_rvalid", 32'(if_rvalid), 32'd1);
    chk("lat_c2_rdata",  if_rdata, 32'h0050_0093);
    chk("lat_c2_stall",  32'(if_stall), 32'd0);
    step(); if_req = 0; mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF; #1;
    chk("lat_c3_rvalid", 32'(if_rvalid), 32'd0);
    chk("lat_hold_rdata", if_rdata, 32'h0050_0093);

    // Store with memory withholding grant for 3 cycles
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_be = 4'b0011; dm_wdata = 32'hAABB_CCDD;
    mem_gnt = 0;
    step();
    dm_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_mreq",  32'(mem_req), 32'd1);
      chk("st_we",    32'(mem_we),  32'd1);
      chk("st_be",    32'(mem_be),  32'h3);
      chk("st_addr",  mem_addr,     32'h100);
      chk("st_wdata", mem_wdata,    32'hAABB_CCDD);
      chk("st_stall", 32'(dm_stall), 32'd1);
      step();
    end
    mem_gnt = 1; #1; chk("st_gnt_mreq", 32'(mem_req), 32'd1);
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("st_rvalid", 32'(dm_rvalid), 32'd1);
    chk("st_stall_done", 32'(dm_stall), 32'd0);
    chk("st_if_quiet", 32'(if_rvalid), 32'd0);
    step(); dm_req = 0; dm_we = 0; mem_rvalid = 0;

    // Both ports requesting continuously: DM x4, IF, DM x4, IF
    if_req = 1; if_addr = 32'h200; dm_req = 1; dm_addr = 32'h300; dm_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      txn(32'h100 + 32'(i), gi, gd, a);
      chk("arb_if",   32'(gi), 32'((i == 4) || (i == 9)));
      chk("arb_dm",   32'(gd), 32'(!((i == 4) || (i == 9))));
      chk("arb_addr", a, ((i == 4) || (i == 9)) ? 32'h200 : 32'h300);
    end
    chk("arb_if_rdata", if_rdata, 32'h109);
    chk("arb_dm_rdata", dm_rdata, 32'h108);
    if_req = 0; dm_req = 0; step();

    // Timeout: memory grants but never responds
    if_req = 1; if_addr = 32'h40; mem_gnt = 1;
    step(); step();
    n = 0; #1;
    while (!if_rvalid && n < 30) begin
      chk("to_no_err_yet", 32'(bus_err), 32'd0);
      step(); #1; n++;
    end
    chk("to_pulse_seen", 32'(n < 30), 32'd1);
    chk("to_rdata_nop", if_rdata, 32'h0000_0013);
    step(); if_req = 0; #1;
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_pulse_once", 32'(if_rvalid), 32'd0);
    step();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D; #1;
    chk("to_late_if",  32'(if_rvalid), 32'd0);
    chk("to_late_dm",  32'(dm_rvalid), 32'd0);
    chk("to_late_rdata", if_rdata, 32'h0000_0013);
    step(); mem_rvalid = 0;

    // Asynchronous reset while in WAIT
    if_req = 1; if_addr = 32'h80; mem_gnt = 1;
    step(); step(); #1;
    chk("rw_in_wait_mreq", 32'(mem_req), 32'd0);
    chk("rw_err_sticky", 32'(bus_err), 32'd1);
    #2 rst = 1'b0; #1;
    chk("rw_bus_err",  32'(bus_err),  32'd0);
    chk("rw_mem_addr", mem_addr,      32'd0);
    chk("rw_if_rdata", if_rdata,      32'd0);
    chk("rw_mem_req",  32'(mem_req),  32'd0);
    if_req = 0;
    @(negedge clk); rst = 1'b1;
    step();
    mem_rvalid = 1; mem_rdata = 32'h7777_7777; #1;
    chk("rw_late_if", 32'(if_rvalid), 32'd0);
    chk("rw_late_dm", 32'(dm_rvalid), 32'd0);
    step(); mem_rvalid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
